// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_ctrl
// Description : HI/LO register controller for a multi-cycle divider.
//               Holds the 32-bit HI and LO registers, services move-to and
//               move-from requests, and sequences a divide through an
//               external divider (held-high start, completion handshake,
//               divide-by-zero exception).
//
//               Optional feature (macro HILO_TIMEOUT_EN):
//                 A 6-bit counter watches the divider wait. If 40 cycles
//                 pass without completion, o_timeout pulses, the divide is
//                 abandoned and HI/LO are left untouched. Without the macro
//                 the wait is unbounded and o_timeout is tied low.
//
// Ports       : clk            rising-edge clock
//               reset          asynchronous active-high reset
//               i_op_valid     request strobe (held until accepted)
//               i_op_code      001 DIV, 010 MTHI, 011 MTLO, 100 MFHI,
//                              101 MFLO, others NOP
//               i_rs_data      write data for MTHI/MTLO
//               o_div_start    held-high divider start
//               i_div_end      divider completion
//               i_div_by_zero  divider zero-divisor flag (with i_div_end)
//               i_div_hi       divider remainder
//               i_div_lo       divider quotient
//               o_busy         requests are not accepted while high
//               o_rd_data      MFHI/MFLO result
//               o_rd_valid     one-cycle qualifier for o_rd_data
//               o_exc_div0     one-cycle divide-by-zero exception
//               o_timeout      one-cycle divider timeout
//
// Revision    : 1.0  initial release
// ============================================================================
module hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_op_valid,
    input  logic [2:0]  i_op_code,
    input  logic [31:0] i_rs_data,
    output logic        o_div_start,
    input  logic        i_div_end,
    input  logic        i_div_by_zero,
    input  logic [31:0] i_div_hi,
    input  logic [31:0] i_div_lo,
    output logic        o_busy,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_exc_div0,
    output logic        o_timeout
);

    localparam logic [2:0] c_OP_DIV  = 3'b001;
    localparam logic [2:0] c_OP_MTHI = 3'b010;
    localparam logic [2:0] c_OP_MTLO = 3'b011;
    localparam logic [2:0] c_OP_MFHI = 3'b100;
    localparam logic [2:0] c_OP_MFLO = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_WAIT = 2'd1,
        S_DIV_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_exc_div0;

    logic        w_accept;     // request taken this edge (IDLE only)
    logic        w_div_cmp;    // divider completion sampled in DIV_WAIT
    logic        w_tmo_hit;    // last permitted DIV_WAIT cycle reached

    // ------------------------------------------------------------------
    // Timeout watchdog
    // ------------------------------------------------------------------
`ifdef HILO_TIMEOUT_EN
    // Counter value during the n-th DIV_WAIT cycle is n-1, so a value of
    // 39 marks the 40th cycle; the abort happens at the end of it.
    localparam logic [5:0] c_TMO_LAST = 6'd39;

    logic [5:0] r_tmo_cnt;
    logic       r_timeout;

    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= 6'd0;
            r_timeout <= 1'b0;
        end else begin
            // Completion on the final cycle takes priority over timeout.
            r_timeout <= (r_state == S_DIV_WAIT) && !i_div_end && w_tmo_hit;
            if (r_state == S_DIV_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 6'd1;
            end else begin
                r_tmo_cnt <= 6'd0;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        o_div_start = 1'b0;
        o_busy      = 1'b0;
        w_accept    = 1'b0;
        w_div_cmp   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = i_op_valid;
                if (i_op_valid && (i_op_code == c_OP_DIV)) begin
                    w_state_nxt = S_DIV_WAIT;
                end
            end
            S_DIV_WAIT: begin
                o_busy      = 1'b1;
                o_div_start = 1'b1;
                if (i_div_end) begin
                    w_div_cmp   = 1'b1;
                    w_state_nxt = S_DIV_DONE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV_DONE: begin
                o_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // HI/LO, read-back and exception registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_rd_data  <= 32'd0;
            r_rd_valid <= 1'b0;
            r_exc_div0 <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_exc_div0 <= 1'b0;

            // w_accept and w_div_cmp come from different states, so the
            // two update sources never collide on the same edge.
            if (w_accept) begin
                case (i_op_code)
                    c_OP_MTHI: r_hi <= i_rs_data;
                    c_OP_MTLO: r_lo <= i_rs_data;
                    c_OP_MFHI: begin
                        r_rd_data  <= r_hi;
                        r_rd_valid <= 1'b1;
                    end
                    c_OP_MFLO: begin
                        r_rd_data  <= r_lo;
                        r_rd_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (w_div_cmp) begin
                if (i_div_by_zero) begin
                    r_exc_div0 <= 1'b1;
                end else begin
                    r_hi <= i_div_hi;
                    r_lo <= i_div_lo;
                end
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_exc_div0 = r_exc_div0;

endmodule
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_ctrl
// Description : Self-checking directed testbench for hilo_ctrl. Inputs are
//               driven and outputs sampled 1 ns after the rising edge. The
//               divider is modelled by hand in each scenario task.
//               Timeout scenario follows HILO_TIMEOUT_EN when defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_ctrl;

    localparam logic [2:0] c_DIV  = 3'b001;
    localparam logic [2:0] c_MTHI = 3'b010;
    localparam logic [2:0] c_MTLO = 3'b011;
    localparam logic [2:0] c_MFHI = 3'b100;
    localparam logic [2:0] c_MFLO = 3'b101;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_data;
    logic        div_start;
    logic        div_end;
    logic        div_by_zero;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        busy;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        exc_div0;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    hilo_ctrl u_dut (
        .clk           (clk),
        .reset         (reset),
        .i_op_valid    (op_valid),
        .i_op_code     (op_code),
        .i_rs_data     (rs_data),
        .o_div_start   (div_start),
        .i_div_end     (div_end),
        .i_div_by_zero (div_by_zero),
        .i_div_hi      (div_hi),
        .i_div_lo      (div_lo),
        .o_busy        (busy),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_exc_div0    (exc_div0),
        .o_timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; caller guarantees the DUT is idle.
    task automatic issue(input logic [2:0] code, input logic [31:0] data);
        op_valid = 1'b1;
        op_code  = code;
        rs_data  = data;
        tick();
        op_valid = 1'b0;
        op_code  = 3'b000;
        rs_data  = 32'd0;
    endtask

    task automatic read_reg(input logic [2:0] code, output logic [31:0] val,
                            output logic vld);
        issue(code, 32'd0);
        val = rd_data;
        vld = rd_valid;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        vl;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start got=%0b want=0", div_start); end
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid got=%0b want=0", rd_valid); end
        checks++; if (exc_div0 !== 1'b0)  begin errors++; $display("FAIL reset_exc_div0 got=%0b want=0", exc_div0); end
        checks++; if (timeout !== 1'b0)   begin errors++; $display("FAIL reset_timeout got=%0b want=0", timeout); end
        checks++; if (rd_data !== 32'd0)  begin errors++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
        reset = 1'b0;
        tick();
        read_reg(c_MFLO, v, vl);
        checks++; if (v !== 32'd0 || vl !== 1'b1) begin errors++; $display("FAIL reset_lo got=%h/%0b want=0/1", v, vl); end
    endtask

    task automatic test_mthi_mfhi();
        logic [31:0] v;
        logic        vl;
        issue(c_MTHI, 32'h0000_1234);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%0b want=0", busy); end
        read_reg(c_MFHI, v, vl);
        checks++; if (vl !== 1'b1)         begin errors++; $display("FAIL mfhi_valid got=%0b want=1", vl); end
        checks++; if (v !== 32'h0000_1234) begin errors++; $display("FAIL mfhi_data got=%h want=00001234", v); end
        tick();
        checks++; if (rd_valid !== 1'b0)         begin errors++; $display("FAIL mfhi_pulse got=%0b want=0", rd_valid); end
        checks++; if (rd_data !== 32'h0000_1234) begin errors++; $display("FAIL rd_data_hold got=%h want=00001234", rd_data); end
    endtask

    task automatic test_div();
        logic [31:0] v;
        logic        vl;
        issue(c_DIV, 32'd0);
        for (int k = 0; k < 34; k++) begin
            checks++;
            if (busy !== 1'b1 || div_start !== 1'b1) begin
                errors++;
                $display("FAIL div_wait cyc=%0d busy=%0b start=%0b want=1/1", k, busy, div_start);
            end
            if (k == 33) begin
                div_end = 1'b1;
                div_hi  = 32'd1;
                div_lo  = 32'd3;
            end
            tick();
        end
        div_end = 1'b0;
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL div_done_busy got=%0b want=1", busy); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL div_done_start got=%0b want=0", div_start); end
        checks++; if (exc_div0 !== 1'b0)  begin errors++; $display("FAIL div_done_exc got=%0b want=0", exc_div0); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_idle_busy got=%0b want=0", busy); end
        read_reg(c_MFHI, v, vl);
        checks++; if (v !== 32'd1 || vl !== 1'b1) begin errors++; $display("FAIL div_hi got=%h/%0b want=1/1", v, vl); end
        read_reg(c_MFLO, v, vl);
        checks++; if (v !== 32'd3 || vl !== 1'b1) begin errors++; $display("FAIL div_lo got=%h/%0b want=3/1", v, vl); end
    endtask

    task automatic test_div0();
        logic [31:0] v;
        logic        vl;
        issue(c_MTHI, 32'hAAAA_AAAA);
        issue(c_MTLO, 32'h5555_5555);
        issue(c_DIV, 32'd0);
        tick();
        tick();
        tick();
        div_end     = 1'b1;
        div_by_zero = 1'b1;
        div_hi      = 32'hDEAD_BEEF;
        div_lo      = 32'h1234_5678;
        tick();
        div_end     = 1'b0;
        div_by_zero = 1'b0;
        checks++; if (exc_div0 !== 1'b1)  begin errors++; $display("FAIL div0_exc got=%0b want=1", exc_div0); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL div0_start got=%0b want=0", div_start); end
        tick();
        checks++; if (exc_div0 !== 1'b0) begin errors++; $display("FAIL div0_pulse got=%0b want=0", exc_div0); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL div0_busy got=%0b want=0", busy); end
        read_reg(c_MFHI, v, vl);
        checks++; if (v !== 32'hAAAA_AAAA) begin errors++; $display("FAIL div0_hi got=%h want=aaaaaaaa", v); end
        read_reg(c_MFLO, v, vl);
        checks++; if (v !== 32'h5555_5555) begin errors++; $display("FAIL div0_lo got=%h want=55555555", v); end
    endtask

    task automatic test_hold_busy();
        logic [31:0] v;
        logic        vl;
        // Phase 1: a held MFHI must not produce a read while busy.
        issue(c_DIV, 32'd0);
        op_valid = 1'b1;
        op_code  = c_MFHI;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL hold_rd_wait cyc=%0d got=%0b want=0", k, rd_valid); end
        end
        div_end = 1'b1;
        div_hi  = 32'h0000_0077;
        div_lo  = 32'h0000_0066;
        tick();
        div_end = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL hold_rd_cmp got=%0b want=0", rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hold_rd_done valid=%0b busy=%0b want=0/0", rd_valid, busy); end
        tick();
        op_valid = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h0000_0077) begin errors++; $display("FAIL hold_rd_accept got=%h/%0b want=77/1", rd_data, rd_valid); end

        // Phase 2: a held MTLO lands on the first edge after busy falls.
        issue(c_DIV, 32'd0);
        op_valid = 1'b1;
        op_code  = c_MTLO;
        rs_data  = 32'hFFFF_0000;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy cyc=%0d got=%0b want=1", k, busy); end
        end
        div_end = 1'b1;
        div_hi  = 32'd7;
        div_lo  = 32'd9;
        tick();
        div_end = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_release got=%0b want=0", busy); end
        tick();
        op_valid = 1'b0;
        rs_data  = 32'd0;
        read_reg(c_MFLO, v, vl);
        checks++; if (v !== 32'hFFFF_0000) begin errors++; $display("FAIL hold_lo got=%h want=ffff0000", v); end
        read_reg(c_MFHI, v, vl);
        checks++; if (v !== 32'd7) begin errors++; $display("FAIL hold_hi got=%h want=7", v); end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] v;
        logic        vl;
        issue(c_MTHI, 32'h11);
        issue(c_MTLO, 32'h22);
        issue(c_DIV, 32'd0);
        tick();
        tick();
        checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL rst_pre_start got=%0b want=1", div_start); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (div_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async start=%0b busy=%0b want=0/0", div_start, busy); end
        tick();
        reset   = 1'b0;
        tick();
        div_end = 1'b1;
        div_hi  = 32'h99;
        div_lo  = 32'h98;
        tick();
        div_end = 1'b0;
        checks++; if (busy !== 1'b0 || exc_div0 !== 1'b0) begin errors++; $display("FAIL rst_late_end busy=%0b exc=%0b want=0/0", busy, exc_div0); end
        read_reg(c_MFHI, v, vl);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_hi got=%h want=0", v); end
        read_reg(c_MFLO, v, vl);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_lo got=%h want=0", v); end
    endtask

    task automatic test_nop();
        logic [31:0] v;
        logic        vl;
        logic [2:0]  nops [3];
        nops[0] = 3'b000;
        nops[1] = 3'b110;
        nops[2] = 3'b111;
        issue(c_MTHI, 32'h5);
        issue(c_MTLO, 32'h6);
        for (int k = 0; k < 3; k++) begin
            issue(nops[k], 32'hFFFF_FFFF);
            checks++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL nop code=%0d busy=%0b valid=%0b want=0/0", nops[k], busy, rd_valid); end
        end
        // Stray completion while idle must be ignored.
        div_end     = 1'b1;
        div_by_zero = 1'b1;
        tick();
        checks++; if (exc_div0 !== 1'b0) begin errors++; $display("FAIL stray_exc got=%0b want=0", exc_div0); end
        div_by_zero = 1'b0;
        div_hi      = 32'h123;
        div_lo      = 32'h456;
        tick();
        div_end     = 1'b0;
        read_reg(c_MFHI, v, vl);
        checks++; if (v !== 32'h5) begin errors++; $display("FAIL nop_hi got=%h want=5", v); end
        read_reg(c_MFLO, v, vl);
        checks++; if (v !== 32'h6) begin errors++; $display("FAIL nop_lo got=%h want=6", v); end
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        logic        vl;
        issue(c_MTHI, 32'hC0FF_EE00);
        issue(c_MTLO, 32'h0000_0001);
        issue(c_DIV, 32'd0);
`ifdef HILO_TIMEOUT_EN
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k < 40) begin
                checks++;
                if (timeout !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_wait cyc=%0d timeout=%0b busy=%0b want=0/1", k, timeout, busy);
                end
            end else begin
                checks++;
                if (timeout !== 1'b1 || busy !== 1'b0 || div_start !== 1'b0) begin
                    errors++;
                    $display("FAIL tmo_fire timeout=%0b busy=%0b start=%0b want=1/0/0", timeout, busy, div_start);
                end
            end
        end
        tick();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse got=%0b want=0", timeout); end
`else
        for (int k = 1; k <= 60; k++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || timeout !== 1'b0 || div_start !== 1'b1) begin
                errors++;
                $display("FAIL notmo_wait cyc=%0d busy=%0b timeout=%0b start=%0b want=1/0/1", k, busy, timeout, div_start);
            end
        end
        div_end     = 1'b1;
        div_by_zero = 1'b1;
        tick();
        div_end     = 1'b0;
        div_by_zero = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL notmo_release got=%0b want=0", busy); end
`endif
        read_reg(c_MFHI, v, vl);
        checks++; if (v !== 32'hC0FF_EE00) begin errors++; $display("FAIL tmo_hi got=%h want=c0ffee00", v); end
        read_reg(c_MFLO, v, vl);
        checks++; if (v !== 32'h0000_0001) begin errors++; $display("FAIL tmo_lo got=%h want=1", v); end
    endtask

    initial begin
        reset       = 1'b1;
        op_valid    = 1'b0;
        op_code     = 3'b000;
        rs_data     = 32'd0;
        div_end     = 1'b0;
        div_by_zero = 1'b0;
        div_hi      = 32'd0;
        div_lo      = 32'd0;

        test_reset();
        test_mthi_mfhi();
        test_div();
        test_div0();
        test_hold_busy();
        test_reset_mid_div();
        test_nop();
        test_timeout();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
